// File: rtl/seg7_scan_driver.sv
// Six-digit multiplexed seven-segment driver: per-frame shadow capture, one digit per slot, blank guard.
// Optional blink support is compiled in with `define SEG7_BLINK_EN.
module seg7_scan_driver #(
  parameter int unsigned CLK_DIV      = 50000,
  parameter int unsigned BLANK_CYCLES = 4,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] seg_bcd5,
  input  logic [3:0] seg_bcd4,
  input  logic [3:0] seg_bcd3,
  input  logic [3:0] seg_bcd2,
  input  logic [3:0] seg_bcd1,
  input  logic [3:0] seg_bcd0,
`ifdef SEG7_BLINK_EN
  input  logic [5:0] blink,
`endif
  output logic [6:0] seg,
  output logic [5:0] an,
  output logic       frame_tick
);
  localparam int unsigned DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  function automatic logic [6:0] decode(input logic [3:0] c);
    case (c)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      4'd10:   decode = 7'b0111111;
      default: decode = 7'b1111111;
    endcase
  endfunction

  logic [DW-1:0]     div_q, div_d;
  logic [2:0]        idx_q, idx_d;
  logic [5:0][3:0]   sh_q, sh_d;
  logic              pend_q;
  logic [6:0]        seg_q, seg_d;
  logic [5:0]        an_q, an_d;
  logic              ft_q;
  logic              div_last, load, blank_digit;

  assign div_last = (32'(div_q) == CLK_DIV - 1);
  assign load     = pend_q | (div_last & (idx_q == 3'd5));

`ifdef SEG7_BLINK_EN
  localparam int unsigned FW = $clog2(BLINK_FRAMES) + 1;
  logic [5:0]    bl_sh_q;
  logic [FW-1:0] fcnt_q;
  logic          phase_q;

  // Phase flips on the load that completes each group of BLINK_FRAMES frame ticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      bl_sh_q <= '0;
      fcnt_q  <= '0;
      phase_q <= 1'b0;
    end else if (load) begin
      bl_sh_q <= blink;
      if (32'(fcnt_q) >= BLINK_FRAMES - 1) begin
        fcnt_q  <= '0;
        phase_q <= ~phase_q;
      end else begin
        fcnt_q <= fcnt_q + FW'(1);
      end
    end
  end

  assign blank_digit = phase_q & bl_sh_q[idx_q];
`else
  assign blank_digit = 1'b0;
`endif

  always_comb begin
    div_d = div_last ? '0 : div_q + DW'(1);
    idx_d = idx_q;
    if (div_last) idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    sh_d  = load ? {seg_bcd5, seg_bcd4, seg_bcd3, seg_bcd2, seg_bcd1, seg_bcd0} : sh_q;
    // Outputs are driven from the pre-edge slot and shadow, so a load edge still shows old idx 5.
    an_d  = 6'h3F;
    seg_d = 7'h7F;
    if (32'(div_q) >= BLANK_CYCLES) begin
      an_d  = ~(6'b1 << idx_q);
      seg_d = blank_digit ? 7'h7F : decode(sh_q[idx_q]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= '0;
      idx_q  <= '0;
      sh_q   <= {6{4'd11}};
      pend_q <= 1'b1;
      seg_q  <= 7'h7F;
      an_q   <= 6'h3F;
      ft_q   <= 1'b0;
    end else begin
      div_q  <= div_d;
      idx_q  <= idx_d;
      sh_q   <= sh_d;
      pend_q <= 1'b0;
      seg_q  <= seg_d;
      an_q   <= an_d;
      ft_q   <= load;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_tick = ft_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: position-based reference model checked every cycle plus literal spot checks.
module tb_seg7_scan_driver;
  localparam int CLK_DIV = 4;
  localparam int BLANK   = 1;
  localparam int BF      = 2;
  localparam int FRAME   = 6 * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] bcd [6];
  logic [5:0] blink;
  logic [6:0] seg;
  logic [5:0] an;
  logic       frame_tick;

  int total = 0;
  int bad   = 0;

  seg7_scan_driver #(.CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst),
    .seg_bcd5(bcd[5]), .seg_bcd4(bcd[4]), .seg_bcd3(bcd[3]),
    .seg_bcd2(bcd[2]), .seg_bcd1(bcd[1]), .seg_bcd0(bcd[0]),
`ifdef SEG7_BLINK_EN
    .blink(blink),
`endif
    .seg(seg), .an(an), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] dec(input logic [3:0] c);
    case (c)
      4'd0: dec = 7'b1000000;  4'd1: dec = 7'b1111001;  4'd2: dec = 7'b0100100;
      4'd3: dec = 7'b0110000;  4'd4: dec = 7'b0011001;  4'd5: dec = 7'b0010010;
      4'd6: dec = 7'b0000010;  4'd7: dec = 7'b1111000;  4'd8: dec = 7'b0000000;
      4'd9: dec = 7'b0010000;  4'd10: dec = 7'b0111111; default: dec = 7'b1111111;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference: everything follows from p, the number of edges since reset release.
  // Loads happen at p==0 and at the last cycle of every frame; frames count from 1 at the first load.
  bit         model_ok = 1'b0;
  int         p, nload;
  logic [3:0] msh [6];
  logic [5:0] mbl;
  logic [6:0] e_seg;
  logic [5:0] e_an;
  logic       e_ft;

  always @(posedge clk) begin
    if (rst) begin
      model_ok = 1'b1;
      p = -1; nload = 0; mbl = '0;
      for (int k = 0; k < 6; k++) msh[k] = 4'd11;
      e_seg = 7'h7F; e_an = 6'h3F; e_ft = 1'b0;
    end else if (model_ok) begin
      int  dv, ix;
      bit  ld, ph;
      p++;
      dv = p % CLK_DIV;
      ix = (p / CLK_DIV) % 6;
      ld = (p == 0) || (p % FRAME == FRAME - 1);
      ph = ((nload / BF) % 2) == 1;
      if (dv < BLANK) begin
        e_an = 6'h3F; e_seg = 7'h7F;
      end else begin
        e_an = 6'h3F & ~(6'd1 << ix);
`ifdef SEG7_BLINK_EN
        e_seg = (ph && mbl[ix]) ? 7'h7F : dec(msh[ix]);
`else
        e_seg = dec(msh[ix]);
`endif
      end
      e_ft = ld;
      if (ld) begin
        for (int k = 0; k < 6; k++) msh[k] = bcd[k];
        mbl = blink;
        nload++;
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("model_seg", 32'(seg), 32'(e_seg));
      chk("model_an", 32'(an), 32'(e_an));
      chk("model_tick", 32'(frame_tick), 32'(e_ft));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_codes(input logic [3:0] c5, c4, c3, c2, c1, c0);
    bcd[5] = c5; bcd[4] = c4; bcd[3] = c3; bcd[2] = c2; bcd[1] = c1; bcd[0] = c0;
  endtask

  logic [6:0] blink_exp;

  initial begin
    rst = 1'b1; blink = '0;
    set_codes(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    tick(3);
    chk("reset_an", 32'(an), 32'h3F);
    chk("reset_seg", 32'(seg), 32'h7F);
    chk("reset_tick", 32'(frame_tick), 32'h0);
    rst = 1'b0;
    tick(1);  chk("first_tick", 32'(frame_tick), 32'h1);        // p=0
    tick(1);  chk("d0_an", 32'(an), 32'h3E);                    // p=1
              chk("d0_seg", 32'(seg), 32'h02);
    tick(4);  chk("d1_an", 32'(an), 32'h3D);                    // p=5
              chk("d1_seg", 32'(seg), 32'h12);
    tick(16); chk("d5_an", 32'(an), 32'h1F);                    // p=21
              chk("d5_seg", 32'(seg), 32'h79);
    tick(2);  chk("frame_tick_24", 32'(frame_tick), 32'h1);     // p=23
    tick(1);  bcd[0] = 4'd10;                                   // p=24, mid-frame change
    tick(2);  chk("no_tear_seg", 32'(seg), 32'h02);             // p=26
    tick(23); chk("minus_seg", 32'(seg), 32'h3F);               // p=49
              chk("minus_an", 32'(an), 32'h3E);
    set_codes(4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd11);
    tick(26); chk("blank_code_seg", 32'(seg), 32'h7F);          // p=75
              chk("blank_code_an", 32'(an), 32'h3E);
    tick(10); chk("idx3_an", 32'(an), 32'h37);                  // p=85, slot 3
    rst = 1'b1; blink = 6'b000001;
    set_codes(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    tick(1);  chk("midscan_rst_an", 32'(an), 32'h3F);
              chk("midscan_rst_seg", 32'(seg), 32'h7F);
              chk("midscan_rst_tick", 32'(frame_tick), 32'h0);
    rst = 1'b0;
    tick(1);  chk("restart_tick", 32'(frame_tick), 32'h1);
    tick(1);  chk("restart_an", 32'(an), 32'h3E);
              chk("restart_seg", 32'(seg), 32'h02);
`ifdef SEG7_BLINK_EN
    blink_exp = 7'h7F;
`else
    blink_exp = 7'h02;
`endif
    tick(24); chk("blink_f2_seg", 32'(seg), 32'(blink_exp));    // p=25
    tick(24); chk("blink_f3_seg", 32'(seg), 32'(blink_exp));    // p=49
    tick(48); chk("blink_f5_seg", 32'(seg), 32'h02);            // p=97
              chk("blink_f5_an", 32'(an), 32'h3E);
    tick(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
